stack_unit: RTL and testbench



---
 rtl/stack_unit_if.sv | 29 ++
 rtl/stack_unit.sv | 90 +++++++++
 tb/tb_stack_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_unit_if.sv
// Stack port bundle: control-unit strobes in, top-of-stack / status out.
// Strobes are sampled on every rising edge; there is no back-pressure.
interface stack_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic [DATA_W-1:0] stack_state;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, push_data, err_clr,
    input  stack_state, pop_data, pop_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output stack_state, pop_data, pop_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack beside the CPU datapath; push+pop together replaces the top entry.
// Define STACK_ERR_STICKY_EN to make overflow/underflow sticky until err_clr.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  stack_unit_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_SP = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   sp;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  logic              is_empty;
  logic              is_full;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              do_pop;
  logic              do_push;
  logic              ovf_evt;
  logic              unf_evt;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == DEPTH_SP);
  // At sp == DEPTH the low bits are zero, so the subtraction lands on DEPTH-1.
  assign top_idx  = sp[ADDR_W-1:0] - 1'b1;

  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    wr_idx  = sp[ADDR_W-1:0];
    do_pop  = bus.pop && !is_empty;
    // A push paired with a successful pop overwrites the top, so fullness is irrelevant.
    do_push = bus.push && (!is_full || do_pop);
    ovf_evt = bus.push && !bus.pop && is_full;
    unf_evt = bus.pop && is_empty;
    if (do_pop) wr_idx = top_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp          <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push && !do_pop) sp <= sp + 1'b1;
      else if (do_pop && !do_push) sp <= sp - 1'b1;
      pop_valid_q <= do_pop;
      if (do_pop) pop_data_q <= mem[top_idx];
`ifdef STACK_ERR_STICKY_EN
      // A new error outranks a coincident clear.
      overflow_q  <= ovf_evt || (overflow_q && !bus.err_clr);
      underflow_q <= unf_evt || (underflow_q && !bus.err_clr);
`else
      overflow_q  <= ovf_evt;
      underflow_q <= unf_evt;
`endif
    end
  end

`ifndef STACK_ERR_STICKY_EN
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
`endif

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= bus.push_data;
  end

  assign bus.stack_state = is_empty ? '0 : mem[top_idx];
  assign bus.pop_data    = pop_data_q;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.count       = sp;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: queue-based reference stack checked every cycle, plus directed literals.
// Follows STACK_ERR_STICKY_EN the same way the design does.
module tb_stack_unit;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  stack_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  stack_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_stack[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_pop_data;
  logic              m_pop_valid;
  logic              m_ovf;
  logic              m_unf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stack.delete();
      m_pop_data  = '0;
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
    end else begin
      logic ovf, unf;
      ovf = bus.push && !bus.pop && (m_stack.size() == DEPTH);
      unf = bus.pop && (m_stack.size() == 0);
      if (bus.pop && m_stack.size() > 0) begin
        m_pop_data  = m_stack[$];
        m_pop_valid = 1'b1;
        exp_q.push_back(m_stack[$]);
        void'(m_stack.pop_back());
        if (bus.push) m_stack.push_back(bus.push_data);
      end else begin
        m_pop_valid = 1'b0;
        if (bus.push && m_stack.size() < DEPTH) m_stack.push_back(bus.push_data);
      end
`ifdef STACK_ERR_STICKY_EN
      m_ovf = ovf || (m_ovf && !bus.err_clr);
      m_unf = unf || (m_unf && !bus.err_clr);
`else
      m_ovf = ovf;
      m_unf = unf;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [DATA_W-1:0] top;
      top = (m_stack.size() == 0) ? '0 : m_stack[$];
      check("count",       32'(bus.count), 32'(m_stack.size()));
      check("stack_state", 32'(bus.stack_state), 32'(top));
      check("full",        32'(bus.full), 32'(m_stack.size() == DEPTH));
      check("empty",       32'(bus.empty), 32'(m_stack.size() == 0));
      check("pop_valid",   32'(bus.pop_valid), 32'(m_pop_valid));
      check("pop_data",    32'(bus.pop_data), 32'(m_pop_data));
      check("overflow",    32'(bus.overflow), 32'(m_ovf));
      check("underflow",   32'(bus.underflow), 32'(m_unf));
      if (bus.pop_valid) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(1), 32'(0));
        else check("pop_order", 32'(bus.pop_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic c);
    @(negedge clk);
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
    bus.err_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},     32'(bus.count), 32'(0));
    check({tag, "_empty"},     32'(bus.empty), 32'(1));
    check({tag, "_full"},      32'(bus.full), 32'(0));
    check({tag, "_state"},     32'(bus.stack_state), 32'(0));
    check({tag, "_pop_data"},  32'(bus.pop_data), 32'(0));
    check({tag, "_pop_valid"}, 32'(bus.pop_valid), 32'(0));
    check({tag, "_ovf"},       32'(bus.overflow), 32'(0));
    check({tag, "_unf"},       32'(bus.underflow), 32'(0));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DATA_W-1:0] lifo_in [3];
    logic [DATA_W-1:0] lifo_out[3];
    tests = 0;
    fails = 0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // LIFO order
    lifo_in  = '{8'h11, 8'h22, 8'h33};
    lifo_out = '{8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, lifo_in[i], 1'b0);
    check("lifo_top", 32'(bus.stack_state), 32'h33);
    check("lifo_count", 32'(bus.count), 32'(3));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      check("lifo_pop_data", 32'(bus.pop_data), 32'(lifo_out[i]));
      check("lifo_pop_valid", 32'(bus.pop_valid), 32'(1));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("lifo_valid_drop", 32'(bus.pop_valid), 32'(0));
    check("lifo_empty", 32'(bus.empty), 32'(1));

    // Overflow
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    check("fill_full", 32'(bus.full), 32'(1));
    check("fill_count", 32'(bus.count), 32'(8));
    step(1'b1, 1'b0, 8'h99, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 32'(1));
    check("ovf_top", 32'(bus.stack_state), 32'h08);
    check("ovf_count", 32'(bus.count), 32'(8));
    step(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef STACK_ERR_STICKY_EN
    check("ovf_sticky", 32'(bus.overflow), 32'(1));
`else
    check("ovf_pulse_end", 32'(bus.overflow), 32'(0));
`endif

    // Underflow
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("drain_last", 32'(bus.pop_data), 32'h01);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("unf_flag", 32'(bus.underflow), 32'(1));
    check("unf_valid", 32'(bus.pop_valid), 32'(0));
    check("unf_hold", 32'(bus.pop_data), 32'h01);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    check("pp_empty_count", 32'(bus.count), 32'(1));
    check("pp_empty_top", 32'(bus.stack_state), 32'h5A);
    check("pp_empty_unf", 32'(bus.underflow), 32'(1));
    check("pp_empty_valid", 32'(bus.pop_valid), 32'(0));
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf", 32'(bus.overflow), 32'(0));
    check("clr_unf", 32'(bus.underflow), 32'(0));

    // Replace top
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'h20, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("rep_pop_data", 32'(bus.pop_data), 32'h20);
    check("rep_pop_valid", 32'(bus.pop_valid), 32'(1));
    check("rep_count", 32'(bus.count), 32'(2));
    check("rep_top", 32'(bus.stack_state), 32'h77);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    check("rep_full_ovf", 32'(bus.overflow), 32'(0));
    check("rep_full_pop", 32'(bus.pop_data), 32'hA5);
    check("rep_full_top", 32'(bus.stack_state), 32'hEE);
    check("rep_full_count", 32'(bus.count), 32'(8));

`ifdef STACK_ERR_STICKY_EN
    // Sticky hold and clear
    step(1'b1, 1'b0, 8'h55, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("sticky_hold", 32'(bus.overflow), 32'(1));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("sticky_clear", 32'(bus.overflow), 32'(0));
    step(1'b1, 1'b0, 8'h56, 1'b1);
    check("sticky_err_wins", 32'(bus.overflow), 32'(1));
`else
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ignored_count", 32'(bus.count), 32'(8));
`endif

    // Asynchronous reset mid-cycle
    step(1'b0, 1'b1, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    check("post_rst_top", 32'(bus.stack_state), 32'hC3);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
